// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: single-outstanding instruction fetch sequencer in front of rom_cache.
// Define ROM_CACHE_PERF_EN to add the hit_count/miss_count lookup counters.
`ifndef CACHE_LENGTH
`define CACHE_LENGTH 8
`endif

package rv32i_pkg;
    localparam int RV_CACHE_LENGTH = `CACHE_LENGTH;
    localparam int RV_ADDR_W       = 32;
    localparam int RV_TAG_W        = RV_ADDR_W - RV_CACHE_LENGTH - 2;

    typedef enum logic [1:0] {
        CACHE_NONE  = 2'd0,
        CACHE_STORE = 2'd2
    } cache_op_e;

    typedef struct packed {
        logic [RV_TAG_W-1:0]        tag;
        logic [RV_CACHE_LENGTH-1:0] index;
    } rv32i_rom_cache_key_s;
endpackage

// state    | meaning
// IDLE     | no fetch outstanding, ready for a request
// LOOKUP   | latched address presented to rom_cache
// ROM_WAIT | miss: rom_req held until rom_ack
// FILL     | returned word written into the cache
// RESP     | fetch_valid pulse, may accept the next request
module rom_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter int CACHE_LENGTH = `CACHE_LENGTH,
    parameter int ADDR_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_W-1:0]    fetch_addr,
    input  logic                 fetch_kill,
    output logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [31:0]          fetch_data,
    output rv32i_rom_cache_key_s cache_addr,
    output logic [31:0]          cache_wdata,
    output cache_op_e            cache_op,
    input  logic                 cache_hit,
    input  logic [31:0]          cache_rdata,
    output logic                 rom_req,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic                 rom_ack,
    input  logic [31:0]          rom_rdata
`ifdef ROM_CACHE_PERF_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_ROM_WAIT = 3'd2;
    localparam logic [2:0] S_FILL     = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-3:0] word_addr;
    logic [31:0]       fill_word;
    logic              kill_flag;
    logic              accept;
    logic              unused_byte_bits;

    assign unused_byte_bits = ^fetch_addr[1:0];

    assign fetch_ready = (state == S_IDLE) || (state == S_RESP);
    assign accept      = fetch_ready && fetch_req;
    assign fetch_valid = (state == S_RESP) && !fetch_kill;
    assign rom_req     = (state == S_ROM_WAIT);
    assign rom_addr    = {word_addr, 2'b00};
    assign cache_op    = (state == S_FILL) ? CACHE_STORE : CACHE_NONE;
    assign cache_wdata = fill_word;

    assign cache_addr.tag   = word_addr[ADDR_W-3:CACHE_LENGTH];
    assign cache_addr.index = word_addr[CACHE_LENGTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_req) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (fetch_kill)     state_nxt = S_IDLE;
                else if (cache_hit) state_nxt = S_RESP;
                else                state_nxt = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                if (rom_ack) state_nxt = S_FILL;
            end
            S_FILL: begin
                state_nxt = (kill_flag || fetch_kill) ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                state_nxt = fetch_req ? S_LOOKUP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            word_addr  <= '0;
            fill_word  <= '0;
            fetch_data <= '0;
            kill_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) word_addr <= fetch_addr[ADDR_W-1:2];
            if (state == S_LOOKUP && cache_hit && !fetch_kill) fetch_data <= cache_rdata;
            // The ROM word is captured once and drives both the fill and the response.
            if (state == S_ROM_WAIT && rom_ack) begin
                fill_word  <= rom_rdata;
                fetch_data <= rom_rdata;
            end
            if (state_nxt == S_IDLE || state_nxt == S_LOOKUP)
                kill_flag <= 1'b0;
            else if ((state == S_ROM_WAIT || state == S_FILL) && fetch_kill)
                kill_flag <= 1'b1;
        end
    end

`ifdef ROM_CACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_LOOKUP) begin
            if (cache_hit) hit_count  <= hit_count + 32'd1;
            else           miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a behavioural rom_cache and ROM responder.
// Build with ROM_CACHE_PERF_EN defined to also check the lookup counters.
module tb_rom_fetch_ctrl;
    import rv32i_pkg::*;

    localparam int NSETS = 2 ** RV_CACHE_LENGTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 fetch_req = 1'b0;
    logic [31:0]          fetch_addr = '0;
    logic                 fetch_kill = 1'b0;
    logic                 fetch_ready;
    logic                 fetch_valid;
    logic [31:0]          fetch_data;
    rv32i_rom_cache_key_s cache_addr;
    logic [31:0]          cache_wdata;
    cache_op_e            cache_op;
    logic                 cache_hit;
    logic [31:0]          cache_rdata;
    logic                 rom_req;
    logic [31:0]          rom_addr;
    logic                 rom_ack = 1'b0;
    logic [31:0]          rom_rdata = '0;
`ifdef ROM_CACHE_PERF_EN
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;
`endif

    rom_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_kill(fetch_kill),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_op(cache_op),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_rdata(rom_rdata)
`ifdef ROM_CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // behavioural direct-mapped rom_cache
    logic                m_val [NSETS];
    logic [RV_TAG_W-1:0] m_tag [NSETS];
    logic [31:0]         m_dat [NSETS];
    logic                model_clr = 1'b1;

    always_comb begin
        cache_hit   = m_val[cache_addr.index] && (m_tag[cache_addr.index] == cache_addr.tag);
        cache_rdata = m_dat[cache_addr.index];
    end

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < NSETS; i++) m_val[i] <= 1'b0;
        end else if (cache_op == CACHE_STORE) begin
            m_val[cache_addr.index] <= 1'b1;
            m_tag[cache_addr.index] <= cache_addr.tag;
            m_dat[cache_addr.index] <= cache_wdata;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          delay;
        int          kill_at;
        bit          exp_valid;
        bit          exp_rom;
        bit          exp_store;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_cnt = 0;
    int ack_delay = 0;
    bit force_ack = 1'b0;
    logic [31:0] rom_word = '0;

    int          valid_cyc [$];
    logic [31:0] valid_dat [$];
    int          rom_cycles;
    logic [31:0] rom_seen_addr;
    int          store_cnt;
    logic [31:0] store_idx;
    logic [31:0] store_dat;
    logic        s_ready, s_valid, s_rom_req;
    logic [31:0] s_data, s_rom_addr, s_wdata, s_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        valid_cyc.delete();
        valid_dat.delete();
        rom_cycles = 0;
        rom_seen_addr = '0;
        store_cnt = 0;
        store_idx = '0;
        store_dat = '0;
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input bit kill);
        @(negedge clk);
        fetch_req  = req;
        fetch_addr = addr;
        fetch_kill = kill;
        if (rom_req) req_cnt++;
        else         req_cnt = 0;
        rom_ack   = force_ack || (rom_req && req_cnt == ack_delay + 1);
        rom_rdata = rom_word;
        #1;
        s_ready    = fetch_ready;
        s_valid    = fetch_valid;
        s_rom_req  = rom_req;
        s_data     = fetch_data;
        s_rom_addr = rom_addr;
        s_wdata    = cache_wdata;
        s_op       = 32'(cache_op);
        if (fetch_valid) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(fetch_data);
        end
        if (rom_req) begin
            rom_cycles++;
            rom_seen_addr = rom_addr;
        end
        if (cache_op == CACHE_STORE) begin
            store_cnt++;
            store_idx = 32'(cache_addr.index);
            store_dat = cache_wdata;
        end
        cyc++;
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int   c0;
        bit   ready0;
        logic [31:0] exp_idx;
        v = vecs[n];
        clear_rec();
        ack_delay = v.delay;
        rom_word  = v.word;
        c0 = cyc;
        step(1'b1, v.addr, v.kill_at == 0);
        ready0 = s_ready;
        for (int r = 1; r <= v.delay + 7; r++) step(1'b0, v.addr, r == v.kill_at);
        chk($sformatf("v%0d_ready_at_accept", n), 32'(ready0), 32'd1);
        chk($sformatf("v%0d_valid_count", n), 32'(valid_cyc.size()), 32'(v.exp_valid));
        if (v.exp_valid && valid_cyc.size() == 1) begin
            chk($sformatf("v%0d_latency", n), 32'(valid_cyc[0] - c0), 32'(v.exp_lat));
            chk($sformatf("v%0d_data", n), valid_dat[0], v.exp_data);
        end
        chk($sformatf("v%0d_rom_access", n), 32'(rom_cycles > 0), 32'(v.exp_rom));
        if (v.exp_rom) chk($sformatf("v%0d_rom_addr", n), rom_seen_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_store_count", n), 32'(store_cnt), 32'(v.exp_store));
        if (v.exp_store) begin
            exp_idx = 32'(v.addr[RV_CACHE_LENGTH+1:2]);
            chk($sformatf("v%0d_store_index", n), store_idx, exp_idx);
            chk($sformatf("v%0d_store_data", n), store_dat, v.word);
        end
        chk($sformatf("v%0d_idle_after", n), 32'(s_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        //        addr          word          dly kill vld rom st  data          lat
        vecs[0]  = '{32'h0000_0100, 32'h0000_0013, 3, -1, 1, 1, 1, 32'h0000_0013, 7};
        vecs[1]  = '{32'h0000_0100, 32'h0,         0, -1, 1, 0, 0, 32'h0000_0013, 2};
        vecs[2]  = '{32'h0000_0500, 32'hAAAA_5555, 0, -1, 1, 1, 1, 32'hAAAA_5555, 4};
        vecs[3]  = '{32'h0000_0100, 32'h0000_0013, 1, -1, 1, 1, 1, 32'h0000_0013, 5};
        vecs[4]  = '{32'h0000_0200, 32'hDEAD_BEEF, 2,  2, 0, 1, 1, 32'h0,         0};
        vecs[5]  = '{32'h0000_0200, 32'h0,         0, -1, 1, 0, 0, 32'hDEAD_BEEF, 2};
        vecs[6]  = '{32'h0000_0300, 32'h1111_2222, 1,  1, 0, 0, 0, 32'h0,         0};
        vecs[7]  = '{32'h0000_0300, 32'h1111_2222, 1,  4, 0, 1, 1, 32'h0,         0};
        vecs[8]  = '{32'h0000_0300, 32'h0,         0,  2, 0, 0, 0, 32'h0,         0};
        vecs[9]  = '{32'h0000_0300, 32'h0,         0, -1, 1, 0, 0, 32'h1111_2222, 2};
        vecs[10] = '{32'h0000_0400, 32'hCAFE_F00D, 0,  4, 0, 1, 1, 32'h0,         0};
        vecs[11] = '{32'h0000_0302, 32'h0,         0, -1, 1, 0, 0, 32'h1111_2222, 2};
        vecs[12] = '{32'h0000_0104, 32'h00A0_0093, 1, -1, 1, 1, 1, 32'h00A0_0093, 5};
        vecs[13] = '{32'h0000_0108, 32'h00B0_0113, 0, -1, 1, 1, 1, 32'h00B0_0113, 4};
        vecs[14] = '{32'h0000_0600, 32'h0060_0613, 0, -1, 1, 1, 1, 32'h0060_0613, 4};

        clear_rec();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        model_clr = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_rom_req", 32'(s_rom_req), 32'd0);
        chk("rst_cache_op", s_op, 32'(CACHE_NONE));
        chk("rst_fetch_data", s_data, 32'h0);
        chk("rst_rom_addr", s_rom_addr, 32'h0);
        chk("rst_cache_wdata", s_wdata, 32'h0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // reset while a miss is waiting on the ROM, then a stale ack
        clear_rec();
        ack_delay = 1000;
        rom_word  = 32'h0BAD_0BAD;
        step(1'b1, 32'h0000_0700, 1'b0);
        step(1'b0, 32'h0000_0700, 1'b0);
        step(1'b0, 32'h0000_0700, 1'b0);
        step(1'b0, 32'h0000_0700, 1'b0);
        chk("mid_rst_rom_req_before", 32'(s_rom_req), 32'd1);
        reset = 1'b1;
        step(1'b0, 32'h0000_0700, 1'b0);
        reset = 1'b0;
        clear_rec();
        force_ack = 1'b1;
        step(1'b0, 32'h0000_0700, 1'b0);
        force_ack = 1'b0;
        chk("mid_rst_rom_req_after", 32'(s_rom_req), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_fetch_data", s_data, 32'h0);
        for (int r = 0; r < 3; r++) step(1'b0, 32'h0000_0700, 1'b0);
        chk("mid_rst_no_fill", 32'(store_cnt), 32'd0);
        chk("mid_rst_no_valid", 32'(valid_cyc.size()), 32'd0);
        chk("mid_rst_no_rom", 32'(rom_cycles), 32'd0);
`ifdef ROM_CACHE_PERF_EN
        chk("perf_rst_hit", hit_count, 32'd0);
        chk("perf_rst_miss", miss_count, 32'd0);
`endif

        run_vec(14);

        // back-to-back hits accepted in RESP
        clear_rec();
        c0 = cyc;
        step(1'b1, 32'h0000_0100, 1'b0);
        step(1'b0, 32'h0000_0100, 1'b0);
        step(1'b1, 32'h0000_0104, 1'b0);
        step(1'b0, 32'h0000_0104, 1'b0);
        step(1'b1, 32'h0000_0108, 1'b0);
        step(1'b0, 32'h0000_0108, 1'b0);
        step(1'b0, 32'h0000_0108, 1'b0);
        step(1'b0, 32'h0000_0108, 1'b0);
        chk("b2b_valid_count", 32'(valid_cyc.size()), 32'd3);
        chk("b2b_rom_access", 32'(rom_cycles), 32'd0);
        if (valid_cyc.size() == 3) begin
            chk("b2b_first_latency", 32'(valid_cyc[0] - c0), 32'd2);
            chk("b2b_gap1", 32'(valid_cyc[1] - valid_cyc[0]), 32'd2);
            chk("b2b_gap2", 32'(valid_cyc[2] - valid_cyc[1]), 32'd2);
            chk("b2b_data0", valid_dat[0], 32'h0000_0013);
            chk("b2b_data1", valid_dat[1], 32'h00A0_0093);
            chk("b2b_data2", valid_dat[2], 32'h00B0_0113);
        end
        for (int r = 0; r < 3; r++) step(1'b0, 32'h0000_0108, 1'b0);
        chk("data_hold", s_data, 32'h00B0_0113);
`ifdef ROM_CACHE_PERF_EN
        chk("perf_miss", miss_count, 32'd1);
        chk("perf_hit", hit_count, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
